// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt source controller.
// Register offsets, gateway states and source IDs.
package intr_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int PRIO_W_DEF  = 3;
  localparam int ADDR_W_DEF  = 8;

  localparam int OFF_PENDING = 'h80;
  localparam int OFF_ENABLE  = 'h84;
  localparam int OFF_THRESH  = 'h88;
  localparam int OFF_CLAIM   = 'h8C;

  localparam int ID_NONE    = 0;
  localparam int ID_UART_TX = 1;
  localparam int ID_UART_RX = 2;
  localparam int ID_TIMER   = 3;
  localparam int ID_EXT     = 4;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_IN_SERVICE
  } gw_state_e;

  function automatic int prio_off(input int id);
    return 4 * id;
  endfunction

endpackage

// File: rtl/intr_gateway.sv
// Per-source gateway: latches a level request and tracks
// it through claim and complete.
module intr_gateway
  import intr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  gw_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GW_IDLE;
    end else begin
      unique case (state)
        GW_IDLE:
          if (src) state <= GW_PENDING;
        GW_PENDING:
          if (claim) state <= GW_IN_SERVICE;
        GW_IN_SERVICE:
          if (complete) state <= GW_IDLE;
        default:
          state <= GW_IDLE;
      endcase
    end
  end

  assign pending    = (state == GW_PENDING);
  assign in_service = (state == GW_IN_SERVICE);

endmodule

// File: rtl/intr_source_ctrl.sv
// Interrupt source controller: gateways, register file,
// priority arbiter and the registered irq line.
module intr_source_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int PRIO_W  = PRIO_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              irq_o
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic [PRIO_W-1:0]  prio_q [1:NUM_SRC];
  logic [NUM_SRC:1]   en_q;
  logic [PRIO_W-1:0]  thr_q;

  logic [NUM_SRC:1]   pend;
  logic [NUM_SRC:1]   insvc;
  logic [NUM_SRC:1]   elig;
  logic [NUM_SRC:1]   claim;
  logic [NUM_SRC:1]   cmpl;
  logic [NUM_SRC:1]   prio_hit;

  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  best_p;
  logic [PRIO_W-1:0]  prio_rd;

  logic sel_pend;
  logic sel_en;
  logic sel_thr;
  logic sel_claim;
  logic wr_ok;
  logic [7:0] cmpl_id;

  logic unused_wdata;
  assign unused_wdata = ^{bus_wdata[31:8], insvc};

  assign sel_pend  = bus_addr == ADDR_W'(OFF_PENDING);
  assign sel_en    = bus_addr == ADDR_W'(OFF_ENABLE);
  assign sel_thr   = bus_addr == ADDR_W'(OFF_THRESH);
  assign sel_claim = bus_addr == ADDR_W'(OFF_CLAIM);
  // A read on the same cycle wins; the write is dropped.
  assign wr_ok     = bus_wr & ~bus_rd;
  assign cmpl_id   = bus_wdata[7:0];

  always_comb begin
    prio_hit = '0;
    prio_rd  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      prio_hit[i] = bus_addr == ADDR_W'(prio_off(i));
      if (prio_hit[i]) prio_rd = prio_q[i];
    end
  end

  genvar g;
  generate
    for (g = 1; g <= NUM_SRC; g++) begin : g_gw
      assign claim[g] = bus_rd & sel_claim
                      & (win_id == ID_W'(g));
      assign cmpl[g]  = wr_ok & sel_claim
                      & (cmpl_id == 8'(g));
      intr_gateway u_gw (
        .clk        (clk),
        .rst        (rst),
        .src        (src_i[g-1]),
        .claim      (claim[g]),
        .complete   (cmpl[g]),
        .pending    (pend[g]),
        .in_service (insvc[g])
      );
    end
  endgenerate

  // Strict compare keeps the lowest ID on equal priority.
  always_comb begin
    elig   = '0;
    best_p = '0;
    win_id = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      elig[i] = pend[i] & en_q[i] & (prio_q[i] > thr_q);
      if (elig[i] && prio_q[i] > best_p) begin
        best_p = prio_q[i];
        win_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
      en_q  <= '0;
      thr_q <= '0;
      irq_o <= 1'b0;
    end else begin
      irq_o <= |elig;
      if (wr_ok) begin
        for (int i = 1; i <= NUM_SRC; i++)
          if (prio_hit[i]) prio_q[i] <= bus_wdata[PRIO_W-1:0];
        if (sel_en)  en_q  <= bus_wdata[NUM_SRC:1];
        if (sel_thr) thr_q <= bus_wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_rd) begin
      unique case (1'b1)
        sel_pend:  bus_rdata = 32'({pend, 1'b0});
        sel_en:    bus_rdata = 32'({en_q, 1'b0});
        sel_thr:   bus_rdata = 32'(thr_q);
        sel_claim: bus_rdata = 32'(win_id);
        |prio_hit: bus_rdata = 32'(prio_rd);
        default:   bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_source_ctrl.sv
// Directed bench for intr_source_ctrl: register access,
// gateway flow, arbitration, threshold and reset.
module tb_intr_source_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  src_i;
  logic [7:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq_o;

  int n_run;
  int n_fail;

  intr_source_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .src_i     (src_i),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
  endtask

  task automatic rd(input logic [7:0] a,
                    output logic [31:0] d);
    bus_addr = a;
    bus_rd   = 1'b1;
    #3;
    d = bus_rdata;
    tick();
    bus_rd   = 1'b0;
    bus_addr = '0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    src_i     = '0;
    bus_addr  = '0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_irq", 32'(irq_o), 0);
    #3;
    chk("rst_rdata_idle", bus_rdata, 0);
    rd_chk("rst_pend", 8'h80, 0);
    rd_chk("rst_en", 8'h84, 0);
    rd_chk("rst_thr", 8'h88, 0);
    rd_chk("rst_claim", 8'h8C, 0);
    rd_chk("rst_prio2", 8'h08, 0);

    // single source flow
    wr(8'h08, 32'h3);
    wr(8'h84, 32'h5);
    rd_chk("en_bit0", 8'h84, 32'h4);
    wr(8'h88, 32'h0);
    src_i = 4'b0010;
    tick();
    src_i = 4'b0000;
    chk("irq_lat0", 32'(irq_o), 0);
    tick();
    chk("irq_lat1", 32'(irq_o), 1);
    rd_chk("pend_s2", 8'h80, 32'h4);
    rd_chk("claim_s2", 8'h8C, 2);
    rd_chk("pend_clr", 8'h80, 0);
    chk("irq_drop", 32'(irq_o), 0);
    wr(8'h8C, 32'h2);
    wr(8'h04, 32'hB);
    rd_chk("prio_mask", 8'h04, 32'h3);
    rd_chk("unmapped", 8'h40, 0);
    wr(8'h40, 32'hFF);
    rd_chk("unmapped_wr", 8'h40, 0);

    // priority order
    wr(8'h04, 32'h2);
    wr(8'h0C, 32'h5);
    wr(8'h84, 32'hA);
    src_i = 4'b0101;
    tick();
    src_i = 4'b0000;
    tick();
    chk("prio_irq", 32'(irq_o), 1);
    rd_chk("prio_claim3", 8'h8C, 3);
    tick();
    chk("prio_irq_hold", 32'(irq_o), 1);
    rd_chk("prio_claim1", 8'h8C, 1);
    tick();
    chk("prio_irq_done", 32'(irq_o), 0);
    wr(8'h8C, 32'h3);
    wr(8'h8C, 32'h1);

    // tie break
    wr(8'h04, 32'h4);
    wr(8'h08, 32'h4);
    wr(8'h84, 32'h6);
    src_i = 4'b0011;
    tick();
    src_i = 4'b0000;
    tick();
    rd_chk("tie_claim1", 8'h8C, 1);
    rd_chk("tie_claim2", 8'h8C, 2);
    rd_chk("tie_none", 8'h8C, 0);
    wr(8'h8C, 32'h1);
    wr(8'h8C, 32'h2);

    // threshold
    wr(8'h88, 32'h4);
    wr(8'h10, 32'h4);
    wr(8'h84, 32'h10);
    src_i = 4'b1000;
    tick();
    src_i = 4'b0000;
    tick();
    tick();
    chk("thr_irq_off", 32'(irq_o), 0);
    rd_chk("thr_claim0", 8'h8C, 0);
    rd_chk("thr_pend", 8'h80, 32'h10);
    wr(8'h88, 32'h3);
    chk("thr_irq_lat", 32'(irq_o), 0);
    tick();
    chk("thr_irq_on", 32'(irq_o), 1);
    rd_chk("thr_claim4", 8'h8C, 4);
    wr(8'h8C, 32'h4);
    wr(8'h88, 32'h0);

    // read and write together: write dropped
    bus_addr  = 8'h88;
    bus_wdata = 32'h5;
    bus_wr    = 1'b1;
    bus_rd    = 1'b1;
    #3;
    chk("rdwr_rdata", bus_rdata, 0);
    tick();
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    rd_chk("rdwr_thr", 8'h88, 0);

    // held level, re-pend, bogus completes
    wr(8'h84, 32'h4);
    src_i = 4'b0010;
    tick();
    tick();
    rd_chk("lvl_claim2", 8'h8C, 2);
    rd_chk("lvl_pend_svc", 8'h80, 0);
    wr(8'h8C, 32'h2);
    rd_chk("lvl_pend_idle", 8'h80, 0);
    rd_chk("lvl_repend", 8'h80, 32'h4);
    rd_chk("lvl_claim2b", 8'h8C, 2);
    wr(8'h8C, 32'h7);
    wr(8'h8C, 32'h0);
    tick();
    rd_chk("bogus_pend", 8'h80, 0);
    rd_chk("bogus_claim", 8'h8C, 0);

    // reset mid-service
    wr(8'h84, 32'h6);
    src_i = 4'b0011;
    tick();
    tick();
    chk("pre_rst_irq", 32'(irq_o), 1);
    rst   = 1'b1;
    src_i = 4'b0000;
    tick();
    chk("rst_mid_irq", 32'(irq_o), 0);
    rst = 1'b0;
    rd_chk("rst_mid_pend", 8'h80, 0);
    rd_chk("rst_mid_en", 8'h84, 0);
    rd_chk("rst_mid_prio", 8'h04, 0);
    wr(8'h8C, 32'h2);
    rd_chk("rst_mid_cmpl", 8'h80, 0);
    tick();
    chk("rst_mid_irq2", 32'(irq_o), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
